enable_loop_sequencer: RTL and testbench

//  Power-up sequencer for the PWR/MTN/BM enable loops. On START it closes PWRENLP, MTNENLP, then BMENLP in order.

---
 rtl/enable_loop_sequencer_if.sv | 27 ++
 rtl/enable_loop_sequencer.sv | 157 +++++++++++++++
 tb/tb_enable_loop_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/enable_loop_sequencer_if.sv
// rtl/enable_loop_sequencer_if.sv - register-block pulses, loop feedback and loop control/status bundle
interface enable_loop_sequencer_if;
  logic       START;
  logic       ABORT;
  logic       CLR_FAULT;
  logic       PWRENLP_STATE;
  logic       MTNENLP_STATE;
  logic       BMENLP_STATE;
  logic       PWRENLP_CNTL;
  logic       MTNENLP_CNTL;
  logic       BMENLP_CNTL;
  logic       BUSY;
  logic       READY;
  logic       FAULT;
  logic [2:0] FAULT_CODE;
  logic [3:0] STAGE;

  modport master (
    output START, ABORT, CLR_FAULT, PWRENLP_STATE, MTNENLP_STATE, BMENLP_STATE,
    input  PWRENLP_CNTL, MTNENLP_CNTL, BMENLP_CNTL, BUSY, READY, FAULT, FAULT_CODE, STAGE
  );

  modport slave (
    input  START, ABORT, CLR_FAULT, PWRENLP_STATE, MTNENLP_STATE, BMENLP_STATE,
    output PWRENLP_CNTL, MTNENLP_CNTL, BMENLP_CNTL, BUSY, READY, FAULT, FAULT_CODE, STAGE
  );
endinterface

// File: rtl/enable_loop_sequencer.sv
// rtl/enable_loop_sequencer.sv - closes PWR, MTN, BM enable loops in order with feedback wait/settle and fault latch
module enable_loop_sequencer #(
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SETTLE_CYCLES  = 10000
) (
  input  logic                   OPB_CLK,
  input  logic                   OPB_RST,
  enable_loop_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_PWR = 4'd1,
    ST_SET_PWR  = 4'd2,
    ST_WAIT_MTN = 4'd3,
    ST_SET_MTN  = 4'd4,
    ST_WAIT_BM  = 4'd5,
    ST_SET_BM   = 4'd6,
    ST_RUN      = 4'd7,
    ST_FAULT    = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       meta_q, sync_q;
  logic [2:0]       cntl_q, cntl_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  logic             lost_pwr, lost_mtn, lost_bm;
  logic             fb;
  logic [2:0]       to_code;
  logic             is_wait, is_set;

  // Bit order {BM, MTN, PWR} throughout.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= {bus.BMENLP_STATE, bus.MTNENLP_STATE, bus.PWRENLP_STATE};
      sync_q <= meta_q;
    end
  end

  // A loop is monitored from its own SET state onward; SET_x loss uses the same path.
  assign lost_pwr = (state_q inside {ST_SET_PWR, ST_WAIT_MTN, ST_SET_MTN, ST_WAIT_BM, ST_SET_BM, ST_RUN}) && !sync_q[0];
  assign lost_mtn = (state_q inside {ST_SET_MTN, ST_WAIT_BM, ST_SET_BM, ST_RUN}) && !sync_q[1];
  assign lost_bm  = (state_q inside {ST_SET_BM, ST_RUN}) && !sync_q[2];

  always_comb begin
    fb      = 1'b0;
    to_code = 3'd0;
    is_wait = 1'b0;
    is_set  = 1'b0;
    case (state_q)
      ST_WAIT_PWR: begin fb = sync_q[0]; to_code = 3'd1; is_wait = 1'b1; end
      ST_WAIT_MTN: begin fb = sync_q[1]; to_code = 3'd2; is_wait = 1'b1; end
      ST_WAIT_BM:  begin fb = sync_q[2]; to_code = 3'd3; is_wait = 1'b1; end
      ST_SET_PWR, ST_SET_MTN, ST_SET_BM: is_set = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    if (state_q == ST_FAULT) begin
      if (bus.CLR_FAULT) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        code_d  = 3'd0;
      end
    end else if (bus.ABORT) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (lost_pwr) begin
      state_d = ST_FAULT;
      code_d  = 3'd4;
    end else if (lost_mtn) begin
      state_d = ST_FAULT;
      code_d  = 3'd5;
    end else if (lost_bm) begin
      state_d = ST_FAULT;
      code_d  = 3'd6;
    end else if (state_q == ST_IDLE) begin
      if (bus.START) begin
        state_d = ST_WAIT_PWR;
        cnt_d   = '0;
      end
    end else if (is_wait) begin
      if (fb) begin
        state_d = state_t'(state_q + 4'd1);
        cnt_d   = '0;
      end else if (cnt_q == TO_LAST) begin
        state_d = ST_FAULT;
        code_d  = to_code;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (is_set) begin
      if (cnt_q == SET_LAST) begin
        state_d = state_t'(state_q + 4'd1);
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so they flip on the edge that enters it.
  always_comb begin
    cntl_d[0] = state_d inside {ST_WAIT_PWR, ST_SET_PWR, ST_WAIT_MTN, ST_SET_MTN, ST_WAIT_BM, ST_SET_BM, ST_RUN};
    cntl_d[1] = state_d inside {ST_WAIT_MTN, ST_SET_MTN, ST_WAIT_BM, ST_SET_BM, ST_RUN};
    cntl_d[2] = state_d inside {ST_WAIT_BM, ST_SET_BM, ST_RUN};
    busy_d    = state_d inside {ST_WAIT_PWR, ST_SET_PWR, ST_WAIT_MTN, ST_SET_MTN, ST_WAIT_BM, ST_SET_BM};
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= 3'd0;
      cntl_q  <= 3'b000;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      cntl_q  <= cntl_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign bus.PWRENLP_CNTL = cntl_q[0];
  assign bus.MTNENLP_CNTL = cntl_q[1];
  assign bus.BMENLP_CNTL  = cntl_q[2];
  assign bus.BUSY         = busy_q;
  assign bus.READY        = ready_q;
  assign bus.FAULT        = fault_q;
  assign bus.FAULT_CODE   = code_q;
  assign bus.STAGE        = state_q;

endmodule

// File: tb/tb_enable_loop_sequencer.sv
// tb/tb_enable_loop_sequencer.sv - vector table plus corner-case sequences against a delayed-feedback loop plant
module tb_enable_loop_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  enable_loop_sequencer_if bus ();

  enable_loop_sequencer #(
    .CNT_W         (24),
    .TIMEOUT_CYCLES(16),
    .SETTLE_CYCLES (4)
  ) dut (
    .OPB_CLK(clk),
    .OPB_RST(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Plant: each loop reports closed 3 clocks after its CNTL rises; kill forces feedback low.
  logic [2:0] d1 = 3'b000, d2 = 3'b000, d3 = 3'b000;
  logic [2:0] kill = 3'b000;
  always @(posedge clk) begin
    d1 <= {bus.BMENLP_CNTL, bus.MTNENLP_CNTL, bus.PWRENLP_CNTL};
    d2 <= d1;
    d3 <= d2;
  end
  assign bus.PWRENLP_STATE = d3[0] & ~kill[0];
  assign bus.MTNENLP_STATE = d3[1] & ~kill[1];
  assign bus.BMENLP_STATE  = d3[2] & ~kill[2];

  typedef struct {
    logic        start;
    logic        abort;
    logic        clr;
    int          cyc;
    logic [12:0] exp;
  } vec_t;

  vec_t        tbl[11];
  logic [12:0] exp_q[$];

  function automatic logic [12:0] ev(input logic [3:0] stg, input logic [2:0] cn,
                                     input logic bz, input logic rd, input logic ft,
                                     input logic [2:0] cd);
    return {stg, cn, bz, rd, ft, cd};
  endfunction

  function automatic logic [12:0] observe();
    return {bus.STAGE, bus.BMENLP_CNTL, bus.MTNENLP_CNTL, bus.PWRENLP_CNTL,
            bus.BUSY, bus.READY, bus.FAULT, bus.FAULT_CODE};
  endfunction

  task automatic check_now(input int id);
    logic [12:0] e;
    logic [12:0] a;
    e = exp_q.pop_front();
    a = observe();
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL check %0d: got stage=%0d cntl=%b busy/ready/fault=%b code=%0d, expected stage=%0d cntl=%b busy/ready/fault=%b code=%0d",
               id, a[12:9], a[8:6], a[5:3], a[2:0], e[12:9], e[8:6], e[5:3], e[2:0]);
    end
  endtask

  // Called at a negedge: pulses last one clock, outputs compared after cyc edges.
  task automatic step(input logic st, input logic ab, input logic cl, input int cyc,
                      input logic [12:0] e, input int id);
    exp_q.push_back(e);
    bus.START     = st;
    bus.ABORT     = ab;
    bus.CLR_FAULT = cl;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.START     = 1'b0;
      bus.ABORT     = 1'b0;
      bus.CLR_FAULT = 1'b0;
    end
    check_now(id);
  endtask

  localparam logic [12:0] E_IDLE = 13'd0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.START     = 1'b0;
    bus.ABORT     = 1'b0;
    bus.CLR_FAULT = 1'b0;

    repeat (3) @(negedge clk);
    exp_q.push_back(E_IDLE);
    check_now(0);
    rst = 1'b0;
    step(0, 0, 0, 2, E_IDLE, 1);

    // Normal sequence, edge numbers counted from the START edge.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, ev(4'd1, 3'b001, 1, 0, 0, 3'd0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 5, ev(4'd1, 3'b001, 1, 0, 0, 3'd0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1, ev(4'd2, 3'b001, 1, 0, 0, 3'd0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 3, ev(4'd2, 3'b001, 1, 0, 0, 3'd0)};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1, ev(4'd3, 3'b011, 1, 0, 0, 3'd0)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 6, ev(4'd4, 3'b011, 1, 0, 0, 3'd0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 4, ev(4'd5, 3'b111, 1, 0, 0, 3'd0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 6, ev(4'd6, 3'b111, 1, 0, 0, 3'd0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 3, ev(4'd6, 3'b111, 1, 0, 0, 3'd0)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1, ev(4'd7, 3'b111, 0, 1, 0, 3'd0)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2, ev(4'd7, 3'b111, 0, 1, 0, 3'd0)};
    for (int i = 0; i < 11; i++)
      step(tbl[i].start, tbl[i].abort, tbl[i].clr, tbl[i].cyc, tbl[i].exp, 10 + i);
    step(0, 1, 0, 1, E_IDLE, 21);
    step(0, 0, 0, 6, E_IDLE, 22);

    // Motion feedback never arrives.
    kill = 3'b010;
    step(1, 0, 0, 1, ev(4'd1, 3'b001, 1, 0, 0, 3'd0), 30);
    step(0, 0, 0, 25, ev(4'd3, 3'b011, 1, 0, 0, 3'd0), 31);
    step(0, 0, 0, 1, ev(4'd8, 3'b000, 0, 0, 1, 3'd2), 32);
    step(0, 1, 0, 1, ev(4'd8, 3'b000, 0, 0, 1, 3'd2), 33);
    kill = 3'b000;
    step(0, 0, 1, 1, E_IDLE, 34);
    step(0, 0, 0, 6, E_IDLE, 35);

    // Simultaneous PWR and BM loss in RUN.
    step(1, 0, 0, 31, ev(4'd7, 3'b111, 0, 1, 0, 3'd0), 40);
    kill = 3'b101;
    step(0, 0, 0, 2, ev(4'd7, 3'b111, 0, 1, 0, 3'd0), 41);
    step(0, 0, 0, 1, ev(4'd8, 3'b000, 0, 0, 1, 3'd4), 42);
    kill = 3'b000;
    step(0, 0, 1, 1, E_IDLE, 43);
    step(0, 0, 0, 6, E_IDLE, 44);

    // BM feedback drops during settle.
    step(1, 0, 0, 26, ev(4'd5, 3'b111, 1, 0, 0, 3'd0), 50);
    kill = 3'b100;
    step(0, 0, 0, 1, ev(4'd6, 3'b111, 1, 0, 0, 3'd0), 51);
    step(0, 0, 0, 1, ev(4'd6, 3'b111, 1, 0, 0, 3'd0), 52);
    step(0, 0, 0, 1, ev(4'd8, 3'b000, 0, 0, 1, 3'd6), 53);
    step(1, 0, 0, 2, ev(4'd8, 3'b000, 0, 0, 1, 3'd6), 54);
    kill = 3'b000;
    step(0, 0, 1, 1, E_IDLE, 55);
    step(0, 0, 0, 6, E_IDLE, 56);

    // Abort mid-sequence, then START+ABORT together in IDLE.
    step(1, 0, 0, 18, ev(4'd4, 3'b011, 1, 0, 0, 3'd0), 60);
    step(0, 1, 0, 1, E_IDLE, 61);
    step(1, 1, 0, 1, E_IDLE, 62);
    step(0, 0, 0, 6, E_IDLE, 63);

    // Asynchronous reset while running.
    step(1, 0, 0, 31, ev(4'd7, 3'b111, 0, 1, 0, 3'd0), 70);
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(E_IDLE);
    check_now(71);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 1, E_IDLE, 72);
    step(0, 0, 0, 4, E_IDLE, 73);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
